// File: rtl/pipelined_addsub_pkg.sv
// rtl/pipelined_addsub_pkg.sv - shared constants and helpers for pipelined_addsub
package pipelined_addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Bits summed per pipeline stage.
  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  // The carry chain must split into equal, non-empty chunks.
  function automatic bit params_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  // One full-adder bit cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// rtl/addsub_chunk.sv - CHUNK-bit combinational ripple of full-adder cells
module addsub_chunk
  import pipelined_addsub_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             msb_cin
);

  // Ripple the carry through the bit cells; the carry entering the top cell feeds overflow detection.
  always_comb begin
    logic [1:0] fa;
    logic       carry;
    fa      = '0;
    carry   = cin;
    msb_cin = cin;
    s       = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) msb_cin = carry;
      fa    = full_add(a[i], b[i], carry);
      s[i]  = fa[0];
      carry = fa[1];
    end
    cout = carry;
  end

endmodule

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - WIDTH-bit add/sub with carry chain split over STAGES registered chunks
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic             ci,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (!params_ok(WIDTH, STAGES)) begin : g_param_check
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // The whole pipe moves in lock-step: it stalls only when a finished result is not taken.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Subtraction is a + ~b + !ci; the borrow convention is restored on co at the last stage.
  assign b_eff   = (op_sub == OP_SUB) ? ~b : b;
  assign cin_eff = (op_sub == OP_SUB) ? !ci : ci;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Values entering this stage, either from the ports or from the previous stage.
    logic             p_valid;
    logic             p_sub;
    logic             p_cin;
    logic [WIDTH-1:0] p_a;
    logic [WIDTH-1:0] p_b;
    logic [WIDTH-1:0] p_s;

    logic [CHUNK-1:0] sum;
    logic             cout;
    logic             msb_cin;
    logic [WIDTH-1:0] s_next;

    // Stage registers: operands keep travelling skewed, finished result chunks travel alongside.
    logic             v_q;
    logic             sub_q;
    logic             c_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;

    if (k == 0) begin : g_src
      assign p_valid = in_valid;
      assign p_sub   = op_sub;
      assign p_cin   = cin_eff;
      assign p_a     = a;
      assign p_b     = b_eff;
      assign p_s     = '0;
    end else begin : g_src
      assign p_valid = g_stage[k-1].v_q;
      assign p_sub   = g_stage[k-1].sub_q;
      assign p_cin   = g_stage[k-1].c_q;
      assign p_a     = g_stage[k-1].a_q;
      assign p_b     = g_stage[k-1].b_q;
      assign p_s     = g_stage[k-1].s_q;
    end

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a       (p_a[k*CHUNK +: CHUNK]),
      .b       (p_b[k*CHUNK +: CHUNK]),
      .cin     (p_cin),
      .s       (sum),
      .cout    (cout),
      .msb_cin (msb_cin)
    );

    // Merge this stage's freshly computed chunk into the lower result bits already done.
    always_comb begin
      s_next                    = p_s;
      s_next[k*CHUNK +: CHUNK]  = sum;
    end

    // Shift on advance, hold everything (bubbles included) on stall.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        sub_q <= 1'b0;
        c_q   <= 1'b0;
        a_q   <= '0;
        b_q   <= '0;
        s_q   <= '0;
      end else if (advance) begin
        v_q   <= p_valid;
        sub_q <= p_sub;
        c_q   <= cout;
        a_q   <= p_a;
        b_q   <= p_b;
        s_q   <= s_next;
      end
    end

    if (k == STAGES - 1) begin : g_out
      // Operands and inter-stage carry are spent once the top chunk is summed.
      logic unused_ops;
      assign unused_ops = ^{a_q, b_q, c_q, sub_q};

      assign out_valid = v_q;
      assign s         = s_q;

      // Carry/borrow and signed overflow come from the top chunk and line up with s.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          co  <= 1'b0;
          ovf <= 1'b0;
        end else if (advance) begin
          co  <= (p_sub == OP_SUB) ? !cout : cout;
          ovf <= msb_cin ^ cout;
        end
      end
    end else begin : g_mid
      // Only the top chunk's MSB carry matters for overflow.
      logic unused_msb;
      assign unused_msb = msb_cin;
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - self-checking bench for pipelined_addsub
module tb_pipelined_addsub;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ovf;
    int          cyc;
    int          stl;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic        rst_n;
  logic        in_valid, in_ready, op_sub, ci, out_valid, out_ready, co, ovf;
  logic [15:0] a, b, s;

  logic [1:0]  iv_sw, or_sw;
  logic        op_sw, ci_sw;
  logic [31:0] a_sw, b_sw;
  logic        ir8, ov8, co8, ovf8, ir32, ov32, co32, ovf32;
  logic [7:0]  s8;
  logic [31:0] s32;

  pipelined_addsub #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
    .ci(ci), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .s(s), .co(co), .ovf(ovf)
  );

  pipelined_addsub #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_sw[0]), .in_ready(ir8), .op_sub(op_sw),
    .ci(ci_sw), .a(a_sw[7:0]), .b(b_sw[7:0]), .out_valid(ov8), .out_ready(or_sw[0]),
    .s(s8), .co(co8), .ovf(ovf8)
  );

  pipelined_addsub #(.WIDTH(32), .STAGES(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_sw[1]), .in_ready(ir32), .op_sub(op_sw),
    .ci(ci_sw), .a(a_sw), .b(b_sw), .out_valid(ov32), .out_ready(or_sw[1]),
    .s(s32), .co(co32), .ovf(ovf32)
  );

  // Reference: plain integer arithmetic on w-bit operands.
  function automatic void ref_addsub(input int w, input logic sub, input logic cin,
                                     input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] rs, output logic rco, output logic rovf);
    logic [63:0] mask, xa, ya, full;
    logic        sa, sb, sr;
    mask = (64'd1 << w) - 64'd1;
    xa   = {32'd0, x} & mask;
    ya   = {32'd0, y} & mask;
    if (sub) full = xa - ya - {63'd0, cin};
    else     full = xa + ya + {63'd0, cin};
    rs   = full[31:0] & mask[31:0];
    rco  = full[w];
    sa   = xa[w-1];
    sb   = ya[w-1];
    sr   = rs[w-1];
    rovf = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
  endfunction

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; op_sub = 1'b0; ci = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    iv_sw = '0; or_sw = '0; op_sw = 1'b0; ci_sw = 1'b0; a_sw = '0; b_sw = '0;
    #1 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({out_valid, in_ready, s, co, ovf} !== {1'b0, 1'b1, 16'h0, 1'b0, 1'b0})
      $display("FAIL reset_state: got valid=%b ready=%b s=%h co=%b ovf=%b, want 0 1 0000 0 0",
               out_valid, in_ready, s, co, ovf);
    else pass_cnt++;
    total_cnt++;
    if ({ov8, ov32, ir8, ir32} !== 4'b0011)
      $display("FAIL reset_sweep_duts: got %b want 0011", {ov8, ov32, ir8, ir32});
    else pass_cnt++;
    #15 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [15:0] va[6]   = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h0009};
    logic [15:0] vb[6]   = '{16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0004};
    logic        vsub[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        vci[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] es[6]   = '{16'h0100, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF, 16'h0004};
    logic        eco[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        eovf[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      int lat;
      out_ready = 1'b1; in_valid = 1'b1; op_sub = vsub[i]; ci = vci[i]; a = va[i]; b = vb[i];
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      total_cnt++;
      if (lat !== 4) $display("FAIL directed_latency[%0d]: got %0d want 4", i, lat);
      else pass_cnt++;
      total_cnt++;
      if ({s, co, ovf} !== {es[i], eco[i], eovf[i]})
        $display("FAIL directed_result[%0d]: got s=%h co=%b ovf=%b want s=%h co=%b ovf=%b",
                 i, s, co, ovf, es[i], eco[i], eovf[i]);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL directed_one_cycle[%0d]: out_valid got %b want 0", i, out_valid);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ta[8], tbv[8];
    logic        tc[8];
    exp_t        q[$];
    exp_t        e;
    int          sent = 0, recv = 0, cyc = 0;
    logic        acc, held, hco, hovf;
    logic [15:0] hs;
    for (int i = 0; i < 8; i++) begin
      ta[i] = 16'($urandom); tbv[i] = 16'($urandom); tc[i] = 1'($urandom_range(0, 1));
    end
    held = 1'b0; hs = '0; hco = 1'b0; hovf = 1'b0;
    while (recv < 8 && cyc < 100) begin
      out_ready = !(cyc >= 5 && cyc < 8);
      op_sub = 1'b0;
      in_valid = (sent < 8);
      if (sent < 8) begin a = ta[sent]; b = tbv[sent]; ci = tc[sent]; end
      #1;
      if (held) begin
        total_cnt++;
        if ({out_valid, s, co, ovf} !== {1'b1, hs, hco, hovf})
          $display("FAIL b2b_stall_stable: got v=%b s=%h co=%b ovf=%b want 1 %h %b %b",
                   out_valid, s, co, ovf, hs, hco, hovf);
        else pass_cnt++;
      end
      if (out_valid && !out_ready) begin
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL b2b_stall_in_ready: got %b want 0", in_ready);
        else pass_cnt++;
      end
      held = out_valid && !out_ready; hs = s; hco = co; hovf = ovf;
      if (out_valid && out_ready) begin
        total_cnt++;
        if (q.size() == 0) $display("FAIL b2b_extra_result: got s=%h with nothing expected", s);
        else begin
          e = q.pop_front();
          if ({s, co, ovf} !== {e.s[15:0], e.co, e.ovf})
            $display("FAIL b2b_result[%0d]: got s=%h co=%b ovf=%b want s=%h co=%b ovf=%b",
                     recv, s, co, ovf, e.s[15:0], e.co, e.ovf);
          else pass_cnt++;
        end
        recv++;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        ref_addsub(16, 1'b0, tc[sent], {16'd0, ta[sent]}, {16'd0, tbv[sent]}, e.s, e.co, e.ovf);
        q.push_back(e);
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total_cnt++;
    if (recv !== 8 || q.size() !== 0)
      $display("FAIL b2b_count: got recv=%0d pending=%0d want 8 and 0", recv, q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n, vcount, lat;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; op_sub = 1'b0; ci = 1'b0; a = 16'h1000 + 16'(i); b = 16'h0234;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    total_cnt++;
    if ({out_valid, s} !== {1'b1, 16'h1234})
      $display("FAIL rstmid_fill: got v=%b s=%h want 1 1234", out_valid, s);
    else pass_cnt++;
    #3 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({out_valid, s, co, ovf, in_ready} !== {1'b0, 16'h0, 1'b0, 1'b0, 1'b1})
      $display("FAIL rstmid_async_clear: got v=%b s=%h co=%b ovf=%b rdy=%b want 0 0000 0 0 1",
               out_valid, s, co, ovf, in_ready);
    else pass_cnt++;
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) vcount++;
    end
    total_cnt++;
    if (vcount !== 0) $display("FAIL rstmid_no_stale: got %0d valid cycles want 0", vcount);
    else pass_cnt++;
    in_valid = 1'b1; op_sub = 1'b0; ci = 1'b0; a = 16'h0003; b = 16'h0004;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    total_cnt++;
    if ({lat, s, co, ovf} !== {32'd4, 16'h0007, 1'b0, 1'b0})
      $display("FAIL rstmid_after: got lat=%0d s=%h co=%b ovf=%b want 4 0007 0 0", lat, s, co, ovf);
    else pass_cnt++;
  endtask

  task automatic test_sweep(input int which, input int w, input int st);
    exp_t        q[$];
    exp_t        e;
    int          cyc = 0, stalls = 0, sent = 0, recv = 0, got_lat;
    logic        hold = 1'b0, acc, ov, ir, gco, govf;
    logic [31:0] gs;
    iv_sw = '0; or_sw = '0;
    while (recv < 40 && cyc < 1000) begin
      if (!hold) begin
        if (sent < 40 && $urandom_range(0, 3) != 0) begin
          iv_sw[which] = 1'b1; op_sw = 1'($urandom_range(0, 1)); ci_sw = 1'($urandom_range(0, 1));
          a_sw = $urandom; b_sw = $urandom;
        end else iv_sw[which] = 1'b0;
      end
      or_sw[which] = ($urandom_range(0, 3) != 0);
      #1;
      ov   = which ? ov32 : ov8;
      ir   = which ? ir32 : ir8;
      gs   = which ? s32 : {24'd0, s8};
      gco  = which ? co32 : co8;
      govf = which ? ovf32 : ovf8;
      if (ov && !or_sw[which]) stalls++;
      if (ov && or_sw[which]) begin
        total_cnt++;
        if (q.size() == 0) $display("FAIL sweep%0d_extra: got s=%h with nothing expected", w, gs);
        else begin
          e = q.pop_front();
          got_lat = cyc - e.cyc - (stalls - e.stl);
          if ({gs, gco, govf} !== {e.s, e.co, e.ovf} || got_lat != st)
            $display("FAIL sweep%0d_result[%0d]: got s=%h co=%b ovf=%b lat=%0d want s=%h co=%b ovf=%b lat=%0d",
                     w, recv, gs, gco, govf, got_lat, e.s, e.co, e.ovf, st);
          else pass_cnt++;
        end
        recv++;
      end
      acc  = iv_sw[which] && ir;
      hold = iv_sw[which] && !ir;
      @(posedge clk); #1;
      if (acc) begin
        ref_addsub(w, op_sw, ci_sw, a_sw, b_sw, e.s, e.co, e.ovf);
        e.cyc = cyc;
        e.stl = stalls;
        q.push_back(e);
        sent++;
      end
      cyc++;
    end
    iv_sw = '0;
    total_cnt++;
    if (recv !== 40 || q.size() !== 0)
      $display("FAIL sweep%0d_count: got recv=%0d pending=%0d want 40 and 0", w, recv, q.size());
    else pass_cnt++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_sweep(0, 8, 1);
    test_sweep(1, 32, 8);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
